// File: rtl/ex_mem_stage.sv
// Execute/memory pipeline latch: registers the execute result bundle and
// runs the data-memory request handshake, freezing upstream while busy.
module ex_mem_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ihit,
  input  logic              stall,
  input  logic              flush,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [DATA_W-1:0] rdat2_in,
  input  logic [DATA_W-1:0] npc_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [REG_W-1:0]  wsel_in,
  input  logic              RegWr_in,
  input  logic              MemtoReg_in,
  input  logic              JAL_in,
  input  logic              halt_in,
  input  logic              dREN_in,
  input  logic              dWEN_in,
  input  logic              dhit,
  input  logic [DATA_W-1:0] dmemload,
  output logic [DATA_W-1:0] alu_out,
  output logic [DATA_W-1:0] npc_out,
  output logic [DATA_W-1:0] pc_out,
  output logic [REG_W-1:0]  wsel_out,
  output logic              RegWr_out,
  output logic              MemtoReg_out,
  output logic              JAL_out,
  output logic [DATA_W-1:0] load_data_out,
  output logic              halt_out,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [DATA_W-1:0] dmemaddr,
  output logic [DATA_W-1:0] dmemstore,
  output logic              mem_busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state;
  logic              ren_q;
  logic              wen_q;
  logic [DATA_W-1:0] rdat2_q;
  logic              advance;

  // Advance is qualified by the current state, so the edge that completes an
  // access never also accepts the next instruction.
  assign advance = ihit & ~stall & (state != WAIT) & ~halt_out;

  assign mem_busy  = (state == WAIT);
  assign dmemREN   = ren_q & (state == WAIT);
  assign dmemWEN   = wen_q & (state == WAIT);
  assign dmemaddr  = alu_out;
  assign dmemstore = rdat2_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= IDLE;
      ren_q         <= 1'b0;
      wen_q         <= 1'b0;
      rdat2_q       <= '0;
      alu_out       <= '0;
      npc_out       <= '0;
      pc_out        <= '0;
      wsel_out      <= '0;
      RegWr_out     <= 1'b0;
      MemtoReg_out  <= 1'b0;
      JAL_out       <= 1'b0;
      halt_out      <= 1'b0;
      load_data_out <= '0;
    end else if (advance) begin
      if (flush) begin
        state         <= IDLE;
        ren_q         <= 1'b0;
        wen_q         <= 1'b0;
        rdat2_q       <= '0;
        alu_out       <= '0;
        npc_out       <= '0;
        pc_out        <= '0;
        wsel_out      <= '0;
        RegWr_out     <= 1'b0;
        MemtoReg_out  <= 1'b0;
        JAL_out       <= 1'b0;
        halt_out      <= 1'b0;
        load_data_out <= '0;
      end else begin
        state         <= (dREN_in | dWEN_in) ? WAIT : IDLE;
        // A store takes priority if both request bits arrive together.
        ren_q         <= dREN_in & ~dWEN_in;
        wen_q         <= dWEN_in;
        rdat2_q       <= rdat2_in;
        alu_out       <= alu_in;
        npc_out       <= npc_in;
        pc_out        <= pc_in;
        wsel_out      <= wsel_in;
        RegWr_out     <= RegWr_in;
        MemtoReg_out  <= MemtoReg_in;
        JAL_out       <= JAL_in;
        halt_out      <= halt_in;
        load_data_out <= '0;
      end
    end else if ((state == WAIT) && dhit) begin
      state <= DONE;
      if (ren_q) begin
        load_data_out <= dmemload;
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed, table-driven bench for ex_mem_stage plus hand-written reset,
// halt and mid-access reset sequences.
module tb_ex_mem_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ihit, stall, flush;
  logic [31:0] alu_in, rdat2_in, npc_in, pc_in;
  logic [4:0]  wsel_in;
  logic        RegWr_in, MemtoReg_in, JAL_in, halt_in, dREN_in, dWEN_in, dhit;
  logic [31:0] dmemload;
  logic [31:0] alu_out, npc_out, pc_out, load_data_out, dmemaddr, dmemstore;
  logic [4:0]  wsel_out;
  logic        RegWr_out, MemtoReg_out, JAL_out, halt_out;
  logic        dmemREN, dmemWEN, mem_busy;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] ih, st, fl, dh, alu, rd2, npc, pc, ws, rw, m2r, jal, hlt, dr, dw, dml;
    logic [31:0] e_alu, e_npc, e_pc, e_ws, e_rw, e_m2r, e_jal, e_hlt;
    logic [31:0] e_ld, e_ren, e_wen, e_busy, e_store;
  } vec_t;

  vec_t vecs[$];

  ex_mem_stage #(.DATA_W(32), .REG_W(5)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .stall(stall), .flush(flush),
    .alu_in(alu_in), .rdat2_in(rdat2_in), .npc_in(npc_in), .pc_in(pc_in),
    .wsel_in(wsel_in), .RegWr_in(RegWr_in), .MemtoReg_in(MemtoReg_in),
    .JAL_in(JAL_in), .halt_in(halt_in), .dREN_in(dREN_in), .dWEN_in(dWEN_in),
    .dhit(dhit), .dmemload(dmemload),
    .alu_out(alu_out), .npc_out(npc_out), .pc_out(pc_out), .wsel_out(wsel_out),
    .RegWr_out(RegWr_out), .MemtoReg_out(MemtoReg_out), .JAL_out(JAL_out),
    .load_data_out(load_data_out), .halt_out(halt_out),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
    .dmemstore(dmemstore), .mem_busy(mem_busy)
  );

  always #5 CLK = ~CLK;

  task automatic addVec(
    input logic [31:0] ih, st, fl, dh, alu, rd2, npc, pc, ws, rw, m2r, jal, hlt, dr, dw, dml,
    input logic [31:0] e_alu, e_npc, e_pc, e_ws, e_rw, e_m2r, e_jal, e_hlt,
    input logic [31:0] e_ld, e_ren, e_wen, e_busy, e_store);
    vec_t v;
    v.ih = ih; v.st = st; v.fl = fl; v.dh = dh; v.alu = alu; v.rd2 = rd2;
    v.npc = npc; v.pc = pc; v.ws = ws; v.rw = rw; v.m2r = m2r; v.jal = jal;
    v.hlt = hlt; v.dr = dr; v.dw = dw; v.dml = dml;
    v.e_alu = e_alu; v.e_npc = e_npc; v.e_pc = e_pc; v.e_ws = e_ws; v.e_rw = e_rw;
    v.e_m2r = e_m2r; v.e_jal = e_jal; v.e_hlt = e_hlt; v.e_ld = e_ld;
    v.e_ren = e_ren; v.e_wen = e_wen; v.e_busy = e_busy; v.e_store = e_store;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    ihit = v.ih[0]; stall = v.st[0]; flush = v.fl[0]; dhit = v.dh[0];
    alu_in = v.alu; rdat2_in = v.rd2; npc_in = v.npc; pc_in = v.pc;
    wsel_in = v.ws[4:0]; RegWr_in = v.rw[0]; MemtoReg_in = v.m2r[0];
    JAL_in = v.jal[0]; halt_in = v.hlt[0]; dREN_in = v.dr[0]; dWEN_in = v.dw[0];
    dmemload = v.dml;
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input vec_t v);
    chk({tag, ".alu_out"},   alu_out,               v.e_alu);
    chk({tag, ".npc_out"},   npc_out,               v.e_npc);
    chk({tag, ".pc_out"},    pc_out,                v.e_pc);
    chk({tag, ".wsel_out"},  {27'b0, wsel_out},     v.e_ws);
    chk({tag, ".RegWr"},     {31'b0, RegWr_out},    v.e_rw);
    chk({tag, ".MemtoReg"},  {31'b0, MemtoReg_out}, v.e_m2r);
    chk({tag, ".JAL"},       {31'b0, JAL_out},      v.e_jal);
    chk({tag, ".halt_out"},  {31'b0, halt_out},     v.e_hlt);
    chk({tag, ".load_data"}, load_data_out,         v.e_ld);
    chk({tag, ".dmemREN"},   {31'b0, dmemREN},      v.e_ren);
    chk({tag, ".dmemWEN"},   {31'b0, dmemWEN},      v.e_wen);
    chk({tag, ".mem_busy"},  {31'b0, mem_busy},     v.e_busy);
    chk({tag, ".dmemaddr"},  dmemaddr,              v.e_alu);
    chk({tag, ".dmemstore"}, dmemstore,             v.e_store);
  endtask

  initial begin
    vec_t z;
    vec_t h;
    z = '{default: '0};

    //     ih st fl dh alu    rd2     npc    pc     ws rw m2r jal hlt dr dw dml
    //     -> alu   npc    pc     ws rw m2r jal hlt ld           ren wen busy store
    addVec(1,0,0,0, 'h10, 0,      'h104, 'h100, 3,1,1,1,0, 0,0, 0,
           'h10, 'h104, 'h100, 3,1,1,1,0, 0,            0,0,0, 0);
    addVec(1,0,0,0, 'h40, 0,      'h108, 'h104, 0,0,0,0,0, 1,0, 0,
           'h40, 'h108, 'h104, 0,0,0,0,0, 0,            1,0,1, 0);
    addVec(0,0,0,0, 'h99, 5,      0,     0,     9,1,0,0,0, 0,0, 0,
           'h40, 'h108, 'h104, 0,0,0,0,0, 0,            1,0,1, 0);
    addVec(1,0,0,0, 'h99, 5,      0,     0,     9,1,0,0,0, 0,0, 0,
           'h40, 'h108, 'h104, 0,0,0,0,0, 0,            1,0,1, 0);
    addVec(1,0,1,0, 'h99, 5,      0,     0,     9,1,0,0,0, 0,0, 0,
           'h40, 'h108, 'h104, 0,0,0,0,0, 0,            1,0,1, 0);
    addVec(1,0,0,1, 'h99, 5,      0,     0,     9,1,0,0,0, 0,0, 'hDEADBEEF,
           'h40, 'h108, 'h104, 0,0,0,0,0, 'hDEADBEEF,   0,0,0, 0);
    addVec(1,1,0,0, 'h55, 0,      0,     0,     0,0,0,0,0, 0,0, 0,
           'h40, 'h108, 'h104, 0,0,0,0,0, 'hDEADBEEF,   0,0,0, 0);
    addVec(1,0,0,0, 'h80, 'h1234, 'h10C, 'h108, 0,0,0,0,0, 0,1, 0,
           'h80, 'h10C, 'h108, 0,0,0,0,0, 0,            0,1,1, 'h1234);
    addVec(0,0,0,0, 0,    0,      0,     0,     0,0,0,0,0, 0,0, 0,
           'h80, 'h10C, 'h108, 0,0,0,0,0, 0,            0,1,1, 'h1234);
    addVec(0,0,0,1, 0,    0,      0,     0,     0,0,0,0,0, 0,0, 'hFFFFFFFF,
           'h80, 'h10C, 'h108, 0,0,0,0,0, 0,            0,0,0, 'h1234);
    addVec(1,0,1,0, 'h77, 5,      1,     2,     5,1,1,1,1, 1,0, 0,
           0,    0,     0,     0,0,0,0,0, 0,            0,0,0, 0);
    addVec(0,0,0,1, 0,    0,      0,     0,     0,0,0,0,0, 0,0, 'h11,
           0,    0,     0,     0,0,0,0,0, 0,            0,0,0, 0);
    addVec(1,0,0,0, 'hC0, 'hAB,   'h110, 'h10C, 4,0,0,0,0, 1,1, 0,
           'hC0, 'h110, 'h10C, 4,0,0,0,0, 0,            0,1,1, 'hAB);
    addVec(0,0,0,1, 0,    0,      0,     0,     0,0,0,0,0, 0,0, 'h22,
           'hC0, 'h110, 'h10C, 4,0,0,0,0, 0,            0,0,0, 'hAB);
    addVec(1,0,0,0, 'h8,  0,      'h114, 'h110, 0,0,0,0,1, 0,0, 0,
           'h8,  'h114, 'h110, 0,0,0,0,1, 0,            0,0,0, 0);
    addVec(1,0,0,0, 'h9,  3,      'h118, 'h114, 7,1,1,1,0, 1,0, 0,
           'h8,  'h114, 'h110, 0,0,0,0,1, 0,            0,0,0, 0);
    addVec(1,0,0,1, 'hA,  0,      0,     0,     2,1,0,0,0, 0,1, 'h33,
           'h8,  'h114, 'h110, 0,0,0,0,1, 0,            0,0,0, 0);

    // Reset with a load presented: nothing may be latched or requested.
    RST = 1'b1;
    h = z;
    h.ih = 1; h.dr = 1; h.alu = 'h40;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(h);
      checkOutput($sformatf("reset%0d", i), z);
    end
    RST = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset clears the sticky halt.
    RST = 1'b1;
    applyStimulus(z);
    checkOutput("halt_reset", z);
    RST = 1'b0;

    // Start a load, then reset in the middle of WAIT.
    h = z;
    h.ih = 1; h.dr = 1; h.alu = 'h40;
    applyStimulus(h);
    h.e_alu = 'h40; h.e_ren = 1; h.e_busy = 1;
    checkOutput("midload_wait", h);
    RST = 1'b1;
    applyStimulus(z);
    checkOutput("midload_reset", z);
    RST = 1'b0;

    // A late dhit after the abandoned access must be ignored.
    h = z;
    h.dh = 1; h.dml = 'h5;
    applyStimulus(h);
    checkOutput("late_dhit", z);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
